// File: rtl/tile_sel_pkg.sv
// tile_sel_pkg
// Shared definitions for the tile select sequencer:
//   - state_t: sequencer states
//   - default timing constants
//   - modulo-N wrap helpers for the select value
package tile_sel_pkg;

    typedef enum logic [1:0] {
        HOLD_RST = 2'd0,
        RUN      = 2'd1,
        WAIT_VS  = 2'd2
    } state_t;

    localparam int DEF_RST_CYCLES      = 64;
    localparam int DEF_DEBOUNCE_CYCLES = 65536;
    localparam int DEF_VS_TIMEOUT      = 1048576;

    // Step forward through tiles 0..n-1, wrapping the last tile back to 0.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v >= n - 1) ? 0 : v + 1;
    endfunction

    // Step backward through tiles 0..n-1, wrapping tile 0 to the last tile.
    function automatic int unsigned wrap_dec(input int unsigned v, input int unsigned n);
        return (v == 0) ? n - 1 : v - 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronizes a raw asynchronous push button into the clk domain, debounces
// it and emits a single-cycle pulse on each accepted press.
// Ports:
//   clk   - pixel clock
//   rst   - synchronous active-high reset, debounced level clears to released
//   btn   - raw button, active-high, asynchronous to clk
//   press - one-cycle pulse on the debounced rising edge (registered)
module btn_debounce
    import tile_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchronizer, then count consecutive samples that disagree
    // with the accepted level; the level flips only once DEBOUNCE_CYCLES
    // disagreeing samples have been seen in a row, and any agreeing sample
    // restarts the count. The press pulse is raised on the flip to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_sel_ctrl.sv
// tile_sel_ctrl
// Shares one HDMI/audio output path among N_TILES tiles. A next/prev press
// mutes video, waits for a vsync rising edge of the running tile (or a
// timeout), then switches the output mux and holds the new tile in reset
// for RST_CYCLES before unmuting.
// Ports:
//   clk        - pixel clock
//   rst        - synchronous active-high reset
//   btn_next   - raw next button
//   btn_prev   - raw prev button
//   vsync_in   - vsync of the currently muxed tile
//   sel        - output mux select
//   tile_ena   - one-hot of sel, to each tile's ena
//   tile_rst_n - per-tile active-low reset
//   video_mute - blanks video downstream
//   busy       - high whenever not in RUN
module tile_sel_ctrl
    import tile_sel_pkg::*;
#(
    parameter int N_TILES         = 4,
    parameter int SEL_W           = $clog2(N_TILES),
    parameter int RST_CYCLES      = DEF_RST_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int VS_TIMEOUT      = DEF_VS_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_next,
    input  logic               btn_prev,
    input  logic               vsync_in,
    output logic [SEL_W-1:0]   sel,
    output logic [N_TILES-1:0] tile_ena,
    output logic [N_TILES-1:0] tile_rst_n,
    output logic               video_mute,
    output logic               busy
);

    // One down-counter serves both the reset hold and the vsync timeout.
    localparam int CNT_MAX = (RST_CYCLES > VS_TIMEOUT) ? RST_CYCLES : VS_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]   RST_LOAD = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   VS_LOAD  = CNT_W'(VS_TIMEOUT - 1);
    localparam logic [N_TILES-1:0] ONE      = N_TILES'(1);

    logic               ev_next;
    logic               ev_prev;
    logic               vs_q;
    logic               vs_q2;
    logic               vs_rise;
    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [SEL_W-1:0]   target;
    logic [SEL_W-1:0]   target_nx;
    logic [SEL_W-1:0]   sel_nx;
    logic [SEL_W-1:0]   sel_inc;
    logic [SEL_W-1:0]   sel_dec;
    logic [N_TILES-1:0] ena_nx;
    logic [N_TILES-1:0] rst_n_nx;
    logic               mute_nx;
    logic               busy_nx;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .press (ev_next)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_prev),
        .press (ev_prev)
    );

    assign sel_inc = SEL_W'(wrap_inc(32'(sel), N_TILES));
    assign sel_dec = SEL_W'(wrap_dec(32'(sel), N_TILES));

    // vsync is compared between two registered copies, so a rise is acted
    // upon one cycle after it is first captured.
    assign vs_rise = vs_q & ~vs_q2;

    // State register; outputs are registered from their next-state values
    // so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HOLD_RST;
            cnt        <= RST_LOAD;
            target     <= '0;
            sel        <= '0;
            vs_q       <= 1'b0;
            vs_q2      <= 1'b0;
            tile_ena   <= ONE;
            tile_rst_n <= '0;
            video_mute <= 1'b1;
            busy       <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            target     <= target_nx;
            sel        <= sel_nx;
            vs_q       <= vsync_in;
            vs_q2      <= vs_q;
            tile_ena   <= ena_nx;
            tile_rst_n <= rst_n_nx;
            video_mute <= mute_nx;
            busy       <= busy_nx;
        end
    end

    // Next-state logic. Presses outside RUN are simply not looked at, so
    // they are dropped; simultaneous next+prev cancel each other.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        target_nx = target;
        sel_nx    = sel;
        unique case (state)
            HOLD_RST: begin
                if (cnt == '0) begin
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            RUN: begin
                if (ev_next ^ ev_prev) begin
                    target_nx = ev_next ? sel_inc : sel_dec;
                    cnt_nx    = VS_LOAD;
                    state_nx  = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (vs_rise || (cnt == '0)) begin
                    sel_nx   = target;
                    cnt_nx   = RST_LOAD;
                    state_nx = HOLD_RST;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                cnt_nx   = RST_LOAD;
                state_nx = HOLD_RST;
            end
        endcase
    end

    // Output decode of the next state. Only the selected tile may ever be
    // out of reset, and it keeps running while we wait for its vsync.
    always_comb begin
        ena_nx   = ONE << sel_nx;
        rst_n_nx = (state_nx == HOLD_RST) ? '0 : ena_nx;
        mute_nx  = (state_nx != RUN);
        busy_nx  = (state_nx != RUN);
    end

endmodule

// File: tb/tb_tile_sel_ctrl.sv
// tb_tile_sel_ctrl
// Bench for tile_sel_ctrl with N_TILES=3, RST_CYCLES=8, DEBOUNCE_CYCLES=4,
// VS_TIMEOUT=100. A directed table walks the main switching scenarios; a
// randomized phase follows. A behavioural model compares every cycle.
module tb_tile_sel_ctrl;

    localparam int NT   = 3;
    localparam int RSTC = 8;
    localparam int DEB  = 4;
    localparam int VST  = 100;
    localparam int MAXE = 16384;

    localparam int P_HOLD = 0;
    localparam int P_RUN  = 1;
    localparam int P_WAIT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       vsync_in = 1'b0;
    logic [1:0] sel;
    logic [2:0] tile_ena;
    logic [2:0] tile_rst_n;
    logic       video_mute;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;

    tile_sel_ctrl #(
        .N_TILES         (NT),
        .SEL_W           (2),
        .RST_CYCLES      (RSTC),
        .DEBOUNCE_CYCLES (DEB),
        .VS_TIMEOUT      (VST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .vsync_in   (vsync_in),
        .sel        (sel),
        .tile_ena   (tile_ena),
        .tile_rst_n (tile_rst_n),
        .video_mute (video_mute),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Compare all outputs against an expected set; one FAIL line per miss.
    task automatic checkOutput(input string name, input logic [1:0] e_sel,
                               input logic [2:0] e_ena, input logic [2:0] e_rstn,
                               input logic e_mute, input logic e_busy);
        vectors++;
        if ({sel, tile_ena, tile_rst_n, video_mute, busy} !==
            {e_sel, e_ena, e_rstn, e_mute, e_busy}) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got sel=%0d ena=%b rst_n=%b mute=%b busy=%b, expected sel=%0d ena=%b rst_n=%b mute=%b busy=%b",
                     name, $time, sel, tile_ena, tile_rst_n, video_mute, busy,
                     e_sel, e_ena, e_rstn, e_mute, e_busy);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit bn, input bit bp, input bit vs);
        rst      = r;
        btn_next = bn;
        btn_prev = bp;
        vsync_in = vs;
    endtask

    // Reference model: raw samples are kept per edge; a debounced level
    // flips when the last DEB synchronized samples (raw delayed two edges)
    // all disagree with it, and the press is acted on one edge later.
    bit hist [3][MAXE];
    int e = 0;
    int last_rst = 0;
    bit lvl  [2];
    bit rose [2];
    int m_phase = P_HOLD;
    int m_elapsed = 0;
    int m_sel = 0;
    int m_target = 0;
    bit model_valid = 1'b0;

    function automatic bit windowFlips(input int b, input bit cur);
        if ((e - DEB + 1 <= last_rst) || (e - DEB + 1 < 2)) return 1'b0;
        for (int k = e - DEB + 1; k <= e; k++)
            if (hist[b][k-2] == cur) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit ev_n;
        bit ev_p;
        bit vs_rise;
        if (e < MAXE) begin
            ev_n = rose[0];
            ev_p = rose[1];
            hist[0][e] = rst ? 1'b0 : btn_next;
            hist[1][e] = rst ? 1'b0 : btn_prev;
            hist[2][e] = rst ? 1'b0 : vsync_in;
            if (rst) begin
                last_rst  = e;
                lvl[0]    = 1'b0;
                lvl[1]    = 1'b0;
                rose[0]   = 1'b0;
                rose[1]   = 1'b0;
                m_phase   = P_HOLD;
                m_elapsed = 0;
                m_sel     = 0;
                m_target  = 0;
            end else begin
                for (int b = 0; b < 2; b++) begin
                    rose[b] = 1'b0;
                    if (windowFlips(b, lvl[b])) begin
                        lvl[b]  = !lvl[b];
                        rose[b] = lvl[b];
                    end
                end
                vs_rise = (e >= 2) && hist[2][e-1] && !hist[2][e-2];
                case (m_phase)
                    P_HOLD: begin
                        m_elapsed++;
                        if (m_elapsed == RSTC) m_phase = P_RUN;
                    end
                    P_RUN: begin
                        if (ev_n != ev_p) begin
                            m_target  = ev_n ? (m_sel + 1) % NT : (m_sel + NT - 1) % NT;
                            m_phase   = P_WAIT;
                            m_elapsed = 0;
                        end
                    end
                    default: begin
                        m_elapsed++;
                        if (vs_rise || (m_elapsed == VST)) begin
                            m_sel     = m_target;
                            m_phase   = P_HOLD;
                            m_elapsed = 0;
                        end
                    end
                endcase
            end
            e++;
            model_valid = 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [2:0] oh;
        if (model_valid && !done) begin
            oh = 3'(1 << m_sel);
            checkOutput("model", 2'(m_sel), oh, (m_phase == P_HOLD) ? 3'b000 : oh,
                        m_phase != P_RUN, m_phase != P_RUN);
        end
    end

    typedef struct {
        bit         r;
        bit         bn;
        bit         bp;
        bit         vs;
        int         cyc;
        logic [1:0] sel;
        logic [2:0] ena;
        logic [2:0] rstn;
        bit         mute;
        bit         busy;
    } vec_t;

    vec_t tbl[$];

    task automatic addVec(input bit r, input bit bn, input bit bp, input bit vs, input int cyc,
                          input logic [1:0] s, input logic [2:0] en, input logic [2:0] rn,
                          input bit mu, input bit bz);
        vec_t v;
        v.r = r; v.bn = bn; v.bp = bp; v.vs = vs; v.cyc = cyc;
        v.sel = s; v.ena = en; v.rstn = rn; v.mute = mu; v.busy = bz;
        tbl.push_back(v);
    endtask

    initial begin
        // Reset and first tile release.
        addVec(1, 0, 0, 0,  3, 2'd0, 3'b001, 3'b000, 1, 1);
        addVec(0, 0, 0, 0,  7, 2'd0, 3'b001, 3'b000, 1, 1);
        addVec(0, 0, 0, 0,  1, 2'd0, 3'b001, 3'b001, 0, 0);
        // Bouncing next button: never stable long enough.
        for (int i = 0; i < 10; i++)
            addVec(0, (i % 2 == 0), 0, 0, 2, 2'd0, 3'b001, 3'b001, 0, 0);
        // Held high: exactly one event, then vsync-triggered switch to 1.
        addVec(0, 1, 0, 0,  6, 2'd0, 3'b001, 3'b001, 0, 0);
        addVec(0, 1, 0, 0,  1, 2'd0, 3'b001, 3'b001, 1, 1);
        addVec(0, 1, 0, 0, 28, 2'd0, 3'b001, 3'b001, 1, 1);
        addVec(0, 1, 0, 1,  1, 2'd0, 3'b001, 3'b001, 1, 1);
        addVec(0, 1, 0, 1,  1, 2'd1, 3'b010, 3'b000, 1, 1);
        addVec(0, 1, 0, 0,  7, 2'd1, 3'b010, 3'b000, 1, 1);
        addVec(0, 1, 0, 0,  1, 2'd1, 3'b010, 3'b010, 0, 0);
        addVec(0, 0, 0, 0,  8, 2'd1, 3'b010, 3'b010, 0, 0);
        // Next toward tile 2, then reset while waiting for vsync.
        addVec(0, 1, 0, 0,  6, 2'd1, 3'b010, 3'b010, 0, 0);
        addVec(0, 1, 0, 0,  1, 2'd1, 3'b010, 3'b010, 1, 1);
        addVec(1, 0, 0, 0,  2, 2'd0, 3'b001, 3'b000, 1, 1);
        addVec(0, 0, 0, 0,  7, 2'd0, 3'b001, 3'b000, 1, 1);
        addVec(0, 0, 0, 0,  1, 2'd0, 3'b001, 3'b001, 0, 0);
        // Prev from tile 0 with vsync low: timeout after 100 cycles.
        addVec(0, 0, 1, 0,  6, 2'd0, 3'b001, 3'b001, 0, 0);
        addVec(0, 0, 1, 0,  1, 2'd0, 3'b001, 3'b001, 1, 1);
        addVec(0, 0, 1, 0, 98, 2'd0, 3'b001, 3'b001, 1, 1);
        addVec(0, 0, 1, 0,  1, 2'd0, 3'b001, 3'b001, 1, 1);
        addVec(0, 0, 0, 0,  1, 2'd2, 3'b100, 3'b000, 1, 1);
        addVec(0, 0, 0, 0,  7, 2'd2, 3'b100, 3'b000, 1, 1);
        addVec(0, 0, 0, 0,  1, 2'd2, 3'b100, 3'b100, 0, 0);
        // Next and prev together: ignored.
        addVec(0, 1, 1, 0, 12, 2'd2, 3'b100, 3'b100, 0, 0);
        addVec(0, 0, 0, 0,  8, 2'd2, 3'b100, 3'b100, 0, 0);
        // Next to tile 0, second press lands in HOLD_RST and is dropped.
        addVec(0, 1, 0, 0,  7, 2'd2, 3'b100, 3'b100, 1, 1);
        addVec(0, 0, 0, 0,  8, 2'd2, 3'b100, 3'b100, 1, 1);
        addVec(0, 1, 0, 1,  2, 2'd0, 3'b001, 3'b000, 1, 1);
        addVec(0, 1, 0, 0,  7, 2'd0, 3'b001, 3'b000, 1, 1);
        addVec(0, 1, 0, 0,  1, 2'd0, 3'b001, 3'b001, 0, 0);
        addVec(0, 1, 0, 0, 10, 2'd0, 3'b001, 3'b001, 0, 0);
        addVec(0, 0, 0, 0,  8, 2'd0, 3'b001, 3'b001, 0, 0);

        // Each step's inputs are seen by exactly cyc rising edges.
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].r, tbl[i].bn, tbl[i].bp, tbl[i].vs);
            repeat (tbl[i].cyc) @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("step%0d", i), tbl[i].sel, tbl[i].ena,
                        tbl[i].rstn, tbl[i].mute, tbl[i].busy);
        end

        // Randomized phase, checked by the model every cycle.
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                repeat ($urandom_range(2, 3)) @(posedge clk);
            end else begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 3) == 0));
                repeat ($urandom_range(1, 14)) @(posedge clk);
            end
            @(negedge clk);
        end

        @(negedge clk);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
